exe_mdu: RTL and testbench

Parametrised multi-cycle multiply/divide unit with architectural HI/LO registers. It sits in the EXE stage beside the ALU. It accepts one MULT/DIV-class operation at a time and stalls the pipeline until the operation completes. Results commit to HI/LO inside the unit, and the unit holds its result until the stage advances. It generalises the fixed 32-bit MULTDIV+HILO pair with configurable width, configurable multiplier pipeline depth, flush cancellation, a done-hold handshake and optional accumulate ops.

---
 rtl/exe_mdu_if.sv | 30 +++
 rtl/exe_mdu.sv | 165 ++++++++++++++++
 tb/tb_exe_mdu.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/exe_mdu_if.sv
// Pipeline-side bundle for the EXE-stage multiply/divide unit: operation
// request, MTHI/MTLO writes, and HI/LO plus handshake status back to the pipeline.
interface exe_mdu_if #(
    parameter int WIDTH = 32
);
    logic             flush;
    logic             start;
    logic             exe_wr;
    logic [2:0]       op;
    logic [WIDTH-1:0] src_a;
    logic [WIDTH-1:0] src_b;
    logic             hi_wr;
    logic             lo_wr;
    logic [WIDTH-1:0] wr_data;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             stall;
    logic             finish;
    logic             busy;

    modport master (
        output flush, start, exe_wr, op, src_a, src_b, hi_wr, lo_wr, wr_data,
        input  hi, lo, stall, finish, busy
    );

    modport slave (
        input  flush, start, exe_wr, op, src_a, src_b, hi_wr, lo_wr, wr_data,
        output hi, lo, stall, finish, busy
    );
endinterface

// File: rtl/exe_mdu.sv
// Multi-cycle multiply/divide unit with architectural HI/LO registers.
// Define MDU_MADD_EN to build the MADD/MADDU/MSUB/MSUBU accumulate ops and the ACC state.
module exe_mdu #(
    parameter int WIDTH      = 32,
    parameter int MUL_STAGES = 2
) (
    input logic      clk,
    input logic      resetn,
    exe_mdu_if.slave mdu
);
    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(MUL_STAGES - 1);
    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [2:0] {IDLE, MUL, ACC, DIV, FIX, DONE} state_t;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [WIDTH-1:0]        hi_q, hi_d;
    logic [WIDTH-1:0]        lo_q, lo_d;
    logic [WIDTH-1:0]        quo_q, quo_d;
    logic [WIDTH-1:0]        rem_q, rem_d;
    logic [WIDTH-1:0]        a_q, b_q;
    logic                    sgn_q;
`ifdef MDU_MADD_EN
    logic                    acc_q, sub_q;
    logic [2*WIDTH-1:0]      acc_res;
`endif

    logic                    legal, accept, is_div;
    logic [WIDTH-1:0]        mag_a, dvs;
    logic                    sa, sb;
    logic signed [2*WIDTH-1:0] ma, mb, prod;
    logic [WIDTH:0]          trial;
    logic                    ge;

`ifdef MDU_MADD_EN
    assign legal = 1'b1;
`else
    assign legal = ~mdu.op[2];
`endif
    assign accept = (state_q == IDLE) && mdu.start && !mdu.flush && legal;
    assign is_div = ~mdu.op[2] & mdu.op[1];
    assign mag_a  = (~mdu.op[0] & mdu.src_a[WIDTH-1]) ? -mdu.src_a : mdu.src_a;

    // Operands are (WIDTH+1)-bit extended, then widened so the low 2*WIDTH bits are exact.
    assign ma   = {{WIDTH{sgn_q & a_q[WIDTH-1]}}, a_q};
    assign mb   = {{WIDTH{sgn_q & b_q[WIDTH-1]}}, b_q};
    assign prod = ma * mb;

    assign sa    = sgn_q & a_q[WIDTH-1];
    assign sb    = sgn_q & b_q[WIDTH-1];
    assign dvs   = sb ? -b_q : b_q;
    assign trial = {rem_q, quo_q[WIDTH-1]};
    assign ge    = trial >= {1'b0, dvs};
`ifdef MDU_MADD_EN
    assign acc_res = sub_q ? ({hi_q, lo_q} - prod) : ({hi_q, lo_q} + prod);
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = is_div ? DIV : MUL;
                    cnt_d   = is_div ? DIV_LAST : MUL_LAST;
                    quo_d   = mag_a;
                    rem_d   = '0;
                end else if (!mdu.start && !mdu.flush) begin
                    if (mdu.hi_wr) hi_d = mdu.wr_data;
                    if (mdu.lo_wr) lo_d = mdu.wr_data;
                end
            end
            MUL: begin
                if (cnt_q == '0) begin
`ifdef MDU_MADD_EN
                    if (acc_q) begin
                        state_d = ACC;
                    end else begin
                        {hi_d, lo_d} = prod;
                        state_d      = DONE;
                    end
`else
                    {hi_d, lo_d} = prod;
                    state_d      = DONE;
`endif
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
`ifdef MDU_MADD_EN
            ACC: begin
                {hi_d, lo_d} = acc_res;
                state_d      = DONE;
            end
`endif
            DIV: begin
                quo_d = {quo_q[WIDTH-2:0], ge};
                rem_d = ge ? (trial[WIDTH-1:0] - dvs) : trial[WIDTH-1:0];
                if (cnt_q == '0) state_d = FIX;
                else             cnt_d   = cnt_q - CNT_W'(1);
            end
            FIX: begin
                if (b_q == '0) begin
                    lo_d = '1;
                    hi_d = a_q;
                end else begin
                    lo_d = (sa ^ sb) ? -quo_q : quo_q;
                    hi_d = sa ? -rem_q : rem_q;
                end
                state_d = DONE;
            end
            DONE: begin
                if (mdu.exe_wr) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // Cancellation beats everything, including a commit in the same cycle.
        if (mdu.flush) begin
            state_d = IDLE;
            hi_d    = hi_q;
            lo_d    = lo_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            a_q   <= mdu.src_a;
            b_q   <= mdu.src_b;
            sgn_q <= ~mdu.op[0];
`ifdef MDU_MADD_EN
            acc_q <= mdu.op[2];
            sub_q <= mdu.op[1];
`endif
        end
        quo_q <= quo_d;
        rem_q <= rem_d;
    end

    assign mdu.hi     = hi_q;
    assign mdu.lo     = lo_q;
    assign mdu.stall  = accept || (state_q == MUL) || (state_q == ACC) ||
                        (state_q == DIV) || (state_q == FIX);
    assign mdu.finish = (state_q == DONE);
    assign mdu.busy   = (state_q != IDLE);
endmodule

// File: tb/tb_exe_mdu.sv
// Directed scoreboard bench for exe_mdu (WIDTH=32, MUL_STAGES=2).
module tb_exe_mdu;
    localparam int W  = 32;
    localparam int MS = 2;

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        string        name;
    } exp_t;

    logic clk;
    logic resetn;
    int   errors = 0;
    int   checks = 0;
    exp_t sb[$];

    exe_mdu_if #(.WIDTH(W)) bus ();

    exe_mdu #(.WIDTH(W), .MUL_STAGES(MS)) dut (
        .clk    (clk),
        .resetn (resetn),
        .mdu    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Monitor: pops one expectation on each entry into DONE.
    initial begin
        logic fin_prev;
        exp_t e;
        fin_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.finish && !fin_prev) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected finish: hi=%h lo=%h with no pending op", bus.hi, bus.lo);
                end else begin
                    e = sb.pop_front();
                    check({e.name, " hi"}, bus.hi, e.hi);
                    check({e.name, " lo"}, bus.lo, e.lo);
                end
            end
            fin_prev = bus.finish;
        end
    end

    task automatic run_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] eh, input logic [W-1:0] el,
                          input int exp_stall, input int hold, input string name);
        int nst;
        bit done;
        sb.push_back('{eh, el, name});
        @(posedge clk); #1;
        bus.start = 1'b1;
        bus.op    = op;
        bus.src_a = a;
        bus.src_b = b;
        nst  = 0;
        done = 1'b0;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk);
            if (bus.stall) nst++;
            if (bus.finish) done = 1'b1;
            else begin
                @(posedge clk); #1;
                bus.src_a = ~a;
                bus.src_b = b ^ 32'h5A5A_0001;
            end
        end
        check({name, " reached done"}, W'(done), W'(1));
        check({name, " stall cycles"}, W'(nst), W'(exp_stall));
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            @(negedge clk);
            check({name, " hold finish"}, W'(bus.finish), W'(1));
            check({name, " hold hi"}, bus.hi, eh);
            check({name, " hold lo"}, bus.lo, el);
        end
        bus.exe_wr = 1'b1;
        bus.start  = 1'b0;
        @(posedge clk); #1;
        bus.exe_wr = 1'b0;
        @(negedge clk);
        check({name, " idle after exe_wr"}, W'(bus.busy), W'(0));
    endtask

    task automatic write_hilo(input logic hw, input logic lw, input logic [W-1:0] data,
                              input logic [W-1:0] eh, input logic [W-1:0] el, input string name);
        @(posedge clk); #1;
        bus.hi_wr   = hw;
        bus.lo_wr   = lw;
        bus.wr_data = data;
        @(posedge clk); #1;
        bus.hi_wr = 1'b0;
        bus.lo_wr = 1'b0;
        @(negedge clk);
        check({name, " hi"}, bus.hi, eh);
        check({name, " lo"}, bus.lo, el);
    endtask

    initial begin
        resetn      = 1'b0;
        bus.flush   = 1'b0;
        bus.start   = 1'b0;
        bus.exe_wr  = 1'b0;
        bus.op      = 3'b000;
        bus.src_a   = '0;
        bus.src_b   = '0;
        bus.hi_wr   = 1'b0;
        bus.lo_wr   = 1'b0;
        bus.wr_data = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset hi", bus.hi, 32'h0);
        check("reset lo", bus.lo, 32'h0);
        check("reset stall", W'(bus.stall), W'(0));
        check("reset finish", W'(bus.finish), W'(0));
        check("reset busy", W'(bus.busy), W'(0));
        @(posedge clk); #1;
        resetn = 1'b1;

        run_op(3'b000, 32'hFFFF_FFFE, 32'h3, 32'hFFFF_FFFF, 32'hFFFF_FFFA, MS + 1, 0, "mult");
        run_op(3'b001, 32'hFFFF_FFFE, 32'h3, 32'h0000_0002, 32'hFFFF_FFFA, MS + 1, 0, "multu");
        run_op(3'b010, 32'hFFFF_FFF9, 32'h2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, W + 2, 0, "div -7/2");
        run_op(3'b010, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, W + 2, 0, "div 7/-2");
        run_op(3'b011, 32'h0000_0007, 32'h0, 32'h0000_0007, 32'hFFFF_FFFF, W + 2, 0, "divu 7/0");
        run_op(3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, W + 2, 0, "div min/-1");
        run_op(3'b011, 32'd100, 32'd7, 32'd2, 32'd14, W + 2, 0, "divu 100/7");

        write_hilo(1'b1, 1'b0, 32'h11, 32'h11, 32'd14, "mthi 11");
        write_hilo(1'b0, 1'b1, 32'h22, 32'h11, 32'h22, "mtlo 22");

        // DIVU cancelled on its 10th DIV cycle.
        @(posedge clk); #1;
        bus.start = 1'b1;
        bus.op    = 3'b011;
        bus.src_a = 32'd1000;
        bus.src_b = 32'd3;
        repeat (10) begin
            @(posedge clk); #1;
        end
        bus.flush = 1'b1;
        bus.start = 1'b0;
        @(negedge clk);
        check("flush busy before", W'(bus.busy), W'(1));
        @(posedge clk); #1;
        bus.flush = 1'b0;
        @(negedge clk);
        check("flush busy after", W'(bus.busy), W'(0));
        check("flush stall after", W'(bus.stall), W'(0));
        check("flush hi kept", bus.hi, 32'h11);
        check("flush lo kept", bus.lo, 32'h22);
        run_op(3'b000, 32'd2, 32'd3, 32'h0, 32'd6, MS + 1, 0, "mult after flush");

`ifdef MDU_MADD_EN
        write_hilo(1'b1, 1'b0, 32'h0, 32'h0, 32'd6, "mthi 0");
        write_hilo(1'b0, 1'b1, 32'hFFFF_FFFF, 32'h0, 32'hFFFF_FFFF, "mtlo ones");
        run_op(3'b101, 32'd1, 32'd1, 32'h1, 32'h0, MS + 2, 0, "maddu 1x1");
        run_op(3'b110, 32'd2, 32'd3, 32'h0, 32'hFFFF_FFFA, MS + 2, 0, "msub 2x3");
        run_op(3'b100, 32'hFFFF_FFFF, 32'd6, 32'h0, 32'hFFFF_FFF4, MS + 2, 0, "madd -1x6");
`else
        @(posedge clk); #1;
        bus.start = 1'b1;
        bus.op    = 3'b111;
        bus.src_a = 32'd5;
        bus.src_b = 32'd5;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("msubu illegal stall", W'(bus.stall), W'(0));
            check("msubu illegal finish", W'(bus.finish), W'(0));
            @(posedge clk); #1;
        end
        bus.start = 1'b0;
        @(negedge clk);
        check("msubu illegal hi", bus.hi, 32'h0);
        check("msubu illegal lo", bus.lo, 32'd6);
`endif

        run_op(3'b000, 32'd7, 32'd9, 32'h0, 32'h3F, MS + 1, 3, "mult hold");
        write_hilo(1'b1, 1'b0, 32'hABCD, 32'hABCD, 32'h3F, "mthi abcd");

        // Reset in the middle of a division.
        @(posedge clk); #1;
        bus.start = 1'b1;
        bus.op    = 3'b010;
        bus.src_a = 32'hFFFF_FFF9;
        bus.src_b = 32'h2;
        repeat (5) begin
            @(posedge clk); #1;
        end
        resetn    = 1'b0;
        bus.start = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        check("midop reset hi", bus.hi, 32'h0);
        check("midop reset lo", bus.lo, 32'h0);
        check("midop reset busy", W'(bus.busy), W'(0));
        check("midop reset stall", W'(bus.stall), W'(0));
        check("midop reset finish", W'(bus.finish), W'(0));
        resetn = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("post reset busy", W'(bus.busy), W'(0));
        check("scoreboard drained", W'(sb.size()), W'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
